// File: rtl/bcd_scan_display.sv
// bcd_scan_display: six-digit time-multiplexed driver for a common-anode
// seven-segment display. The time is snapshotted once per scan frame so a
// frame never mixes old and new digits. The block also provides anti-ghost
// blanking at the start of each slot, per-digit blink, flashing colon DPs
// and hour leading-zero blanking.
module bcd_scan_display #(
    parameter int SCAN_DIV  = 1000,      // clock cycles per digit slot (>= 2)
    parameter int BLANK_CYC = 20,        // all-anodes-off cycles at slot start
    parameter int BLINK_DIV = 25000000,  // clock cycles per blink half-period
    parameter bit LZB       = 1'b1       // blank hour-tens digit when it is 0
) (
    input  logic       CP,
    input  logic       nCLR,
    input  logic [7:0] Hour,
    input  logic [7:0] Min,
    input  logic [7:0] Sec,
    input  logic [5:0] Blink,
    output logic [5:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END  = PRE_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [2:0]       IDX_LAST   = 3'd5;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      snap_q, snap_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0]       digit;
    logic             seg_blank;

    // Next-state logic: slot prescaler, digit index, frame snapshot, blink timer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        pre_d         = pre_q + 1'b1;
        idx_d         = idx_q;
        snap_d        = snap_q;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;

        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (idx_q == IDX_LAST) begin
                // Entering slot 0: take a fresh copy of the time for the whole frame.
                idx_d  = '0;
                snap_d = {Hour, Min, Sec};
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Output decode: digit select, segment pattern, blanking overrides and colon DP.
    always_comb begin
        case (idx_q)
            3'd0:    digit = snap_q[3:0];    // seconds ones
            3'd1:    digit = snap_q[7:4];    // seconds tens
            3'd2:    digit = snap_q[11:8];   // minutes ones
            3'd3:    digit = snap_q[15:12];  // minutes tens
            3'd4:    digit = snap_q[19:16];  // hours ones
            default: digit = snap_q[23:20];  // hours tens
        endcase

        // Anodes stay dark briefly at each slot start so the previous digit's
        // segments do not ghost onto the newly selected anode.
        if (pre_q < BLANK_END) an_d = 6'h3F;
        else                   an_d = ~(6'b00_0001 << idx_q);

        case (digit)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h3F;  // non-BCD nibble shows a dash
        endcase

        // Blink is taken live so set-mode feedback does not wait for a frame.
        seg_blank = (Blink[idx_q] && blink_phase_q) ||
                    (LZB && (idx_q == IDX_LAST) && (snap_q[23:20] == 4'h0));
        if (seg_blank) seg_d = 7'h7F;

        // Colon dots sit after the minutes-ones and hours-ones digits.
        dp_d = ~(((idx_q == 3'd2) || (idx_q == 3'd4)) && !blink_phase_q && (an_d != 6'h3F));
    end

    // State and registered outputs, all cleared asynchronously by nCLR.
    always_ff @(posedge CP or negedge nCLR) begin
        if (!nCLR) begin
            pre_q         <= '0;
            idx_q         <= '0;
            snap_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 6'h3F;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: scoreboard bench for bcd_scan_display. A cycle-level
// reference model pushes the expected outputs for each clock edge, and each
// scenario task pops them and compares after the edge. Fixed expectations
// for the scan pattern are checked as well.
module tb_bcd_scan_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int BLINK_DIV = 16;

    logic       CP = 1'b0;
    logic       nCLR = 1'b0;
    logic [7:0] Hour = '0;
    logic [7:0] Min = '0;
    logic [7:0] Sec = '0;
    logic [5:0] Blink = '0;
    logic [5:0] AN;
    logic [6:0] SEG;
    logic       DP;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    out_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state. m_s counts clock edges since reset release.
    int          m_pre, m_idx, m_bcnt, m_s;
    bit          m_phase;
    logic [23:0] m_snap;

    bcd_scan_display #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .BLINK_DIV(BLINK_DIV),
        .LZB      (1'b1)
    ) dut (
        .CP   (CP),
        .nCLR (nCLR),
        .Hour (Hour),
        .Min  (Min),
        .Sec  (Sec),
        .Blink(Blink),
        .AN   (AN),
        .SEG  (SEG),
        .DP   (DP)
    );

    always #5 CP = ~CP;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic out_t model_out(input int pre, input int idx, input logic [23:0] snap,
                                       input bit phase, input logic [5:0] blk);
        out_t       o;
        logic [3:0] nib;
        logic [2:0] i3;
        i3    = idx[2:0];
        nib   = snap[idx*4 +: 4];
        o.an  = (pre < BLANK_CYC) ? 6'h3F : ~(6'b00_0001 << i3);
        o.seg = seg_of(nib);
        if ((blk[i3] && phase) || (idx == 5 && nib == 4'h0)) o.seg = 7'h7F;
        o.dp  = ((idx == 2 || idx == 4) && !phase && o.an != 6'h3F) ? 1'b0 : 1'b1;
        return o;
    endfunction

    task automatic model_reset();
        m_pre   = 0;
        m_idx   = 0;
        m_bcnt  = 0;
        m_phase = 1'b0;
        m_snap  = '0;
        m_s     = 0;
        sb.delete();
    endtask

    // One clock edge: push what the DUT must register on it, advance the model.
    task automatic tick();
        sb.push_back(model_out(m_pre, m_idx, m_snap, m_phase, Blink));
        @(posedge CP);
        if (m_pre == SCAN_DIV - 1) begin
            m_pre = 0;
            if (m_idx == 5) begin
                m_idx  = 0;
                m_snap = {Hour, Min, Sec};
            end else begin
                m_idx++;
            end
        end else begin
            m_pre++;
        end
        if (m_bcnt == BLINK_DIV - 1) begin
            m_bcnt  = 0;
            m_phase = ~m_phase;
        end else begin
            m_bcnt++;
        end
        m_s++;
        #1;
    endtask

    task automatic test_reset();
        out_t exp, got;
        nCLR = 1'b1;
        model_reset();
        repeat (6) begin
            tick();
            exp = sb.pop_front();
            got = {AN, SEG, DP};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_scan s=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                         m_s - 1, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
            end
            if (m_s == 1) begin
                checks++;
                if (AN !== 6'h3F) begin
                    errors++;
                    $display("FAIL reset_first_blank: got AN=%h, want 3F", AN);
                end
            end
            if (m_s == 2) begin
                checks++;
                if (AN !== 6'h3E || SEG !== 7'h40) begin
                    errors++;
                    $display("FAIL reset_first_digit: got AN=%h SEG=%h, want AN=3E SEG=40", AN, SEG);
                end
            end
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 nCLR = 1'b0;
        #1;
        checks++;
        if (AN !== 6'h3F || SEG !== 7'h7F || DP !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: got AN=%h SEG=%h DP=%b, want AN=3F SEG=7F DP=1", AN, SEG, DP);
        end
        @(posedge CP);
        #1;
        checks++;
        if (AN !== 6'h3F || SEG !== 7'h7F || DP !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: got AN=%h SEG=%h DP=%b, want AN=3F SEG=7F DP=1", AN, SEG, DP);
        end
        nCLR = 1'b1;
        model_reset();
    endtask

    task automatic test_digit_sequence();
        out_t       exp, got;
        int         s, pre, slot;
        logic [5:0] an_tab[6]  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        logic [6:0] seg_tab[6] = '{7'h78, 7'h30, 7'h12, 7'h19, 7'h10, 7'h7F};
        logic       dp_tab[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        Hour = 8'h09;
        Min  = 8'h45;
        Sec  = 8'h37;
        repeat (48) begin
            tick();
            exp = sb.pop_front();
            got = {AN, SEG, DP};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL digit_seq s=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                         m_s - 1, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
            end
            if (m_s >= 25) begin
                s    = m_s - 1;
                pre  = s % 4;
                slot = (s / 4) % 6;
                if (pre == 0) begin
                    checks++;
                    if (AN !== 6'h3F) begin
                        errors++;
                        $display("FAIL digit_blank slot=%0d: got AN=%h, want 3F", slot, AN);
                    end
                end else begin
                    checks++;
                    if (AN !== an_tab[slot] || SEG !== seg_tab[slot] || DP !== dp_tab[slot]) begin
                        errors++;
                        $display("FAIL digit_table slot=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                                 slot, AN, SEG, DP, an_tab[slot], seg_tab[slot], dp_tab[slot]);
                    end
                end
            end
        end
    endtask

    task automatic test_tearing();
        out_t exp, got;
        while (m_s < 78) begin
            tick();
            exp = sb.pop_front();
            got = {AN, SEG, DP};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL tearing s=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                         m_s - 1, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
            end
            if (m_s == 61) Sec = 8'h38;  // mid-frame change during slot 3
            if (m_s == 74) begin
                checks++;
                if (AN !== 6'h3E || SEG !== 7'h00) begin
                    errors++;
                    $display("FAIL tearing_new_frame: got AN=%h SEG=%h, want AN=3E SEG=00", AN, SEG);
                end
            end
            if (m_s == 78) begin
                checks++;
                if (AN !== 6'h3D || SEG !== 7'h30) begin
                    errors++;
                    $display("FAIL tearing_tens: got AN=%h SEG=%h, want AN=3D SEG=30", AN, SEG);
                end
            end
        end
    endtask

    task automatic test_invalid_bcd();
        out_t exp, got;
        Min = 8'h4A;
        while (m_s < 120) begin
            tick();
            exp = sb.pop_front();
            got = {AN, SEG, DP};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL invalid s=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                         m_s - 1, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
            end
            if (m_s == 106) begin
                checks++;
                if (AN !== 6'h3B || SEG !== 7'h3F) begin
                    errors++;
                    $display("FAIL invalid_dash: got AN=%h SEG=%h, want AN=3B SEG=3F", AN, SEG);
                end
            end
            if (m_s == 110) begin
                checks++;
                if (AN !== 6'h37 || SEG !== 7'h19) begin
                    errors++;
                    $display("FAIL invalid_tens: got AN=%h SEG=%h, want AN=37 SEG=19", AN, SEG);
                end
            end
        end
        Min = 8'h45;
    endtask

    task automatic test_blink_colon();
        out_t       exp, got;
        int         s, pre, slot;
        bit         phase;
        logic [5:0] want_an;
        logic [6:0] want_seg;
        Blink = 6'b000011;
        while (m_s < 168) begin
            tick();
            exp = sb.pop_front();
            got = {AN, SEG, DP};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL blink s=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                         m_s - 1, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
            end
            s     = m_s - 1;
            pre   = s % 4;
            slot  = (s / 4) % 6;
            phase = ((s / 16) % 2) == 1;
            if (pre != 0 && slot < 2) begin
                want_an  = (slot == 0) ? 6'h3E : 6'h3D;
                want_seg = phase ? 7'h7F : ((slot == 0) ? 7'h00 : 7'h30);
                checks++;
                if (AN !== want_an || SEG !== want_seg) begin
                    errors++;
                    $display("FAIL blink_digit s=%0d: got AN=%h SEG=%h, want AN=%h SEG=%h",
                             s, AN, SEG, want_an, want_seg);
                end
            end
            if (pre != 0 && (slot == 2 || slot == 4)) begin
                checks++;
                if (DP !== phase) begin
                    errors++;
                    $display("FAIL colon_dp s=%0d: got DP=%b, want %b", s, DP, phase);
                end
            end
        end
        Blink = 6'b000000;
    endtask

    task automatic test_reset_mid_frame();
        out_t exp, got;
        while (m_s < 186) begin
            tick();
            exp = sb.pop_front();
            got = {AN, SEG, DP};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pre_reset s=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                         m_s - 1, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
            end
        end
        #1 nCLR = 1'b0;
        #1;
        checks++;
        if (AN !== 6'h3F || SEG !== 7'h7F || DP !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset: got AN=%h SEG=%h DP=%b, want AN=3F SEG=7F DP=1", AN, SEG, DP);
        end
        Hour = 8'h12;
        Min  = 8'h34;
        Sec  = 8'h56;
        @(posedge CP);
        #1 nCLR = 1'b1;
        model_reset();
        repeat (48) begin
            tick();
            exp = sb.pop_front();
            got = {AN, SEG, DP};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset s=%0d: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                         m_s - 1, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
            end
            if (m_s == 2) begin
                checks++;
                if (AN !== 6'h3E || SEG !== 7'h40) begin
                    errors++;
                    $display("FAIL post_reset_zero: got AN=%h SEG=%h, want AN=3E SEG=40", AN, SEG);
                end
            end
            if (m_s == 26) begin
                checks++;
                if (AN !== 6'h3E || SEG !== 7'h02) begin
                    errors++;
                    $display("FAIL post_reset_snap: got AN=%h SEG=%h, want AN=3E SEG=02", AN, SEG);
                end
            end
            if (m_s == 46) begin
                checks++;
                if (AN !== 6'h1F || SEG !== 7'h79) begin
                    errors++;
                    $display("FAIL post_reset_hour_tens: got AN=%h SEG=%h, want AN=1F SEG=79", AN, SEG);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CP);
        #1;
        test_reset();
        test_digit_sequence();
        test_tearing();
        test_invalid_bcd();
        test_blink_colon();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
